// File: rtl/led_fill_bar_if.sv
// Button/LED bundle for the bar-graph fill driver.
// Ports: button (start request, master->slave), led[15:0] (bar, slave->master).
interface led_fill_bar_if;
    logic        button;
    logic [15:0] led;

    modport master (
        output button,
        input  led
    );

    modport slave (
        input  button,
        output led
    );
endinterface

// File: rtl/led_fill_bar.sv
// Bar-graph LED driver: a button press arms the block, then one more LED
// lights per clock from bit 0 upward until all 16 are lit, and holds there.
// Ports: clk (system clock), rst (sync active-low reset),
//        bar.slave (button in, led[15:0] out).
module led_fill_bar (
    input  logic          clk,
    input  logic          rst,
    led_fill_bar_if.slave bar
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } arm_e;

    localparam logic [4:0] FULL = 5'd16;

    arm_e       state;
    arm_e       state_nxt;
    logic [4:0] level;
    logic [4:0] level_nxt;
    logic       go;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            level <= '0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
        end
    end

    // A press both arms and advances on the same edge.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        go        = bar.button | (state == ARMED);
        if (bar.button) begin
            state_nxt = ARMED;
        end
        if (go && (level != FULL)) begin
            level_nxt = level + 5'd1;
        end
    end

    // Thermometer decode of registered level only: bit i lit when i < level.
    always_comb begin
        bar.led = '0;
        for (int i = 0; i < 16; i++) begin
            bar.led[i] = (5'(i) < level);
        end
    end

endmodule

// File: tb/tb_led_fill_bar.sv
// Scoreboard bench for led_fill_bar: a reference model pushes the expected
// bar per edge, and the DUT output is popped and compared after each edge.
module tb_led_fill_bar;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    led_fill_bar_if bus ();

    led_fill_bar dut (
        .clk (clk),
        .rst (rst),
        .bar (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    int          m_level;
    bit          m_start;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bar_of(input int lvl);
        logic [31:0] v;
        v = (32'd1 << lvl) - 32'd1;
        return v[15:0];
    endfunction

    task automatic step(input string tag, input logic b, input logic r);
        logic [15:0] e;
        @(negedge clk);
        bus.button = b;
        rst        = r;
        if (!r) begin
            m_start = 0;
            m_level = 0;
        end else begin
            if ((b || m_start) && m_level < 16) m_level++;
            if (b) m_start = 1;
        end
        exp_q.push_back(bar_of(m_level));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s got=empty exp=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, bus.led, e);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        m_level    = 0;
        m_start    = 0;
        rst        = 1'b0;
        bus.button = 1'b0;

        step("reset0", 1'b0, 1'b0);
        step("reset1", 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("idle", 1'b0, 1'b1);

        step("rst_a", 1'b0, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            step("held", 1'b1, 1'b1);
            if (k <= 16) chk("held_const", bus.led, bar_of(k));
        end

        step("rst_b", 1'b0, 1'b0);
        step("pre1", 1'b0, 1'b1);
        step("pre2", 1'b0, 1'b1);
        step("pulse", 1'b1, 1'b1);
        chk("pulse_first", bus.led, 16'h0001);
        for (int i = 0; i < 17; i++) step("pulse_run", 1'b0, 1'b1);
        chk("pulse_full", bus.led, 16'hFFFF);

        step("rst_c", 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("half", 1'b1, 1'b1);
        chk("half_ff", bus.led, 16'h00FF);
        step("mid_rst", 1'b0, 1'b0);
        chk("mid_rst_zero", bus.led, 16'h0000);
        for (int i = 0; i < 5; i++) step("disarmed", 1'b0, 1'b1);
        step("repress", 1'b1, 1'b1);
        chk("refill", bus.led, 16'h0001);
        for (int i = 0; i < 3; i++) step("refill_run", 1'b0, 1'b1);

        step("btn_rst", 1'b1, 1'b0);
        chk("btn_rst_zero", bus.led, 16'h0000);
        for (int i = 0; i < 5; i++) step("not_armed", 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step("sat_rand", 1'($urandom_range(0, 1)), 1'b1);
            chk("sat_hold", bus.led, 16'hFFFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
